// File: rtl/seq_gen_00101_if.sv
// Handshake/data bundle for the 00101 burst generator: burst request in, serial pattern out.
interface seq_gen_00101_if;
  logic       start;
  logic [3:0] count;
  logic       out;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output count,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  count,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_gen_00101.sv
// Burst generator emitting N back-to-back copies of the serial pattern 00101.
// Define SEQ_GEN_GAP_EN to insert a single guard '1' cycle between consecutive copies.
module seq_gen_00101 (
  input  logic             clk,
  input  logic             reset,
  seq_gen_00101_if.slave   bus
);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd3
  } state_e;
`endif

  localparam logic [2:0] LastIdx = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_q, out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Pattern bit at a given index, in time order 0,0,1,0,1.
  function automatic logic pattern_bit(input logic [2:0] idx);
    logic bit_val;
    bit_val = 1'b0;
    case (idx)
      3'd2:    bit_val = 1'b1;
      3'd4:    bit_val = 1'b1;
      default: bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = bus.count;
          idx_d   = 3'd0;
          state_d = (bus.count != 4'd0) ? StSend : StDone;
        end
      end
      StSend: begin
        if (idx_q == LastIdx) begin
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
            idx_d = 3'd0;
`ifdef SEQ_GEN_GAP_EN
            state_d = StGap;
`else
            state_d = StSend;
`endif
          end else begin
            state_d = StDone;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      StGap: begin
        state_d = StSend;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    out_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StSend: begin
        out_d  = pattern_bit(idx_d);
        busy_d = 1'b1;
      end
`ifdef SEQ_GEN_GAP_EN
      StGap: begin
        out_d  = 1'b1;
        busy_d = 1'b1;
      end
`endif
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        out_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/seq_gen_00101.md
SEQ_GEN_00101 -- requirements
Module: seq_gen_00101

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-005 count  input  4  number of 00101 copies in the burst (0-15); latched when start is accepted.
REQ-006 out  output  1  registered serial pattern bit, one bit per clk.
REQ-007 busy  output  1  high while a burst is being emitted.
REQ-008 done  output  1  single-cycle pulse marking the end of a burst.

Function
REQ-009 The block SHALL implement the states IDLE, SEND, GAP and DONE. GAP exists only when SEQ_GEN_GAP_EN is defined.
REQ-010 In IDLE, the block SHALL accept start=1 at edge k. It SHALL latch count into a 4-bit copies-remaining counter and clear the 3-bit bit index to 0.
REQ-011 If the latched count is nonzero, the block SHALL go to SEND, and out SHALL show bit 0 of the pattern in the cycle after edge k.
REQ-012 Each copy SHALL be emitted as 0,0,1,0,1 in time order, advancing one bit per edge, with the bit index running 0 to 4.
REQ-013 When index 4 is emitted and copies remaining is greater than 1, the block SHALL decrement the counter and reset the index to 0.
- Without SEQ_GEN_GAP_EN: emission continues directly in SEND, with no idle cycle between copies.
- With SEQ_GEN_GAP_EN: the block enters GAP instead (see REQ-025).
REQ-014 When index 4 is emitted and copies remaining equals 1, the next edge SHALL enter DONE.
REQ-015 In DONE, the block SHALL drive done=1, busy=0 and out=0 for exactly one cycle, then return to IDLE on the following edge.
REQ-016 If start is accepted with count=0, the block SHALL go directly to DONE on the next edge. No pattern bits are emitted and busy stays 0.
REQ-017 busy SHALL be 1 in every SEND and GAP cycle, and 0 in IDLE and DONE.
REQ-018 out SHALL be 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in SEND, GAP and DONE. A start held high through DONE SHALL begin a new burst at the first IDLE edge.
REQ-020 The latched count SHALL NOT change when the count input changes during a burst.
REQ-021 A full burst of N copies SHALL take exactly 5N busy cycles, plus (N-1) with SEQ_GEN_GAP_EN. The done pulse SHALL occur in the cycle immediately after the last busy cycle.

Reset
REQ-022 While reset=1 at a rising edge, the block SHALL enter IDLE and clear out, busy, done, the index and the counter to 0.
REQ-023 Reset SHALL have priority over start.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no done pulse. The first accepted start after reset deasserts SHALL begin a fresh burst.

Configuration
REQ-025 With macro SEQ_GEN_GAP_EN defined, the block SHALL insert one GAP cycle between consecutive copies, with out=1 and busy=1. No GAP cycle is inserted after the last copy.
- Copies are therefore separated by a single guard 1, so a downstream overlapping 00101 detector cannot see cross-copy matches.
REQ-026 Without SEQ_GEN_GAP_EN, the GAP state and its logic SHALL be absent, and copies SHALL be emitted back-to-back.

Verification
REQ-027 Reset held 5 cycles, then start=1 with count=1 for one cycle:
- out = 0,0,1,0,1 over the next 5 cycles with busy=1;
- then done=1, busy=0 for 1 cycle;
- then IDLE.
REQ-028 count=2 without SEQ_GEN_GAP_EN: out = 0010100101 over 10 busy cycles, and done pulses in cycle 11.
REQ-029 count=2 with SEQ_GEN_GAP_EN: out = 00101100101 over 11 busy cycles, and done pulses in cycle 12.
REQ-030 count=0 with start=1: busy stays 0, out stays 0, and done pulses exactly one cycle after the start edge.
REQ-031 Run count=3, pulse start again at bit 7, and change count to 9 at bit 8:
- the second start is ignored;
- the burst stays at 15 bits (without the macro);
- a single done pulse is produced.
REQ-032 Assert reset at bit 6 of a count=2 burst:
- out, busy and done go to 0 at the next edge, with no done pulse;
- a following start with count=1 produces 00101 normally.
